// File: rtl/hybrid_mult_pkg.sv
// Shared definitions for the hybrid multiplier MAC path: widths, defaults,
// accumulator FSM states and parameter legality helpers.
package hybrid_mult_pkg;

    localparam int PROD_W        = 16;
    localparam int ACC_W_DEFAULT = 24;
    localparam int LEN_DEFAULT   = 8;
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    function automatic bit len_legal(input int len);
        return (len >= 1) && (len <= 255);
    endfunction

    function automatic bit acc_w_legal(input int acc_w);
        return (acc_w >= 16) && (acc_w <= 32);
    endfunction

endpackage

// File: rtl/hybrid_product_accumulator_if.sv
// Product-in and group-sum-out handshakes of the product accumulator.
interface hybrid_product_accumulator_if #(
    parameter int ACC_W = hybrid_mult_pkg::ACC_W_DEFAULT
);
    import hybrid_mult_pkg::*;

    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_ovf;

    // master: product source and sum sink; slave: the accumulator itself
    modport master (
        output prod_valid, prod_data, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_ovf
    );

    modport slave (
        input  prod_valid, prod_data, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_ovf
    );

endinterface

// File: rtl/hybrid_product_accumulator_sat_accum_add.sv
// Combinational saturating adder: ACC_W-bit accumulator plus 16-bit product,
// clamped to all-ones when the carry out of ACC_W bits is set.
module sat_accum_add
    import hybrid_mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] sum_wide;

    assign sum_wide = {1'b0, acc} + (ACC_W+1)'(prod);
    assign ovf      = sum_wide[ACC_W];

    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_sat
        assign sum[gi] = sum_wide[gi] | ovf;
    end

endmodule

// File: rtl/hybrid_product_accumulator.sv
// Sums groups of LEN multiplier products into a saturating accumulator and
// presents each group sum through a valid/ready handshake.
module hybrid_product_accumulator
    import hybrid_mult_pkg::*;
#(
    parameter int LEN   = LEN_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    hybrid_product_accumulator_if.slave  bus,
    output logic                         busy
);

    if (!len_legal(LEN)) begin : g_len_check
        $error("hybrid_product_accumulator: LEN must be in 1..255");
    end
    if (!acc_w_legal(ACC_W)) begin : g_acc_w_check
        $error("hybrid_product_accumulator: ACC_W must be in 16..32");
    end

    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(LEN);

    acc_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             live_reg;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             beat;

    sat_accum_add #(.ACC_W(ACC_W)) u_add (
        .acc  (acc_reg),
        .prod (bus.prod_data),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    // live_reg keeps prod_ready low through reset while staying a pure register decode
    assign bus.prod_ready = live_reg && (state_reg != HOLD);
    assign bus.acc_valid  = (state_reg == HOLD);
    assign bus.acc_data   = acc_reg;
    assign bus.acc_ovf    = ovf_reg;
    assign busy           = (state_reg != IDLE);
    assign beat           = bus.prod_valid && bus.prod_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            live_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            live_reg  <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (beat) begin
                    // a lone 16-bit product can never saturate a >=16-bit accumulator
                    acc_next   = ACC_W'(bus.prod_data);
                    cnt_next   = CNT_W'(1);
                    ovf_next   = 1'b0;
                    state_next = (LEN_CNT == CNT_W'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_next = add_sum;
                    ovf_next = ovf_reg | add_ovf;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_next == LEN_CNT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.acc_ready) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
